trace_arbiter: RTL and testbench

TRACE_ARBITER -- requirements
Module: trace_arbiter

---
 rtl/trace_arbiter.sv | 134 +++++++++++++
 tb/tb_trace_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_arbiter.sv
// trace_arbiter: collects single-cycle trace records from NUM_SRC trackers into
// one holding slot per source, and forwards them one at a time to a downstream
// sink through a round-robin arbiter with a valid/ready handshake. Also provides
// the shared free-running cycle counter that the trackers timestamp against.
module trace_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int REC_WIDTH = 128,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trace_en,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REC_WIDTH-1:0] src_data,
  input  logic                         trace_ready,
  output logic                         trace_valid,
  output logic [REC_WIDTH-1:0]         trace_data,
  output logic [$clog2(NUM_SRC)-1:0]   trace_src,
  output logic [CNT_WIDTH-1:0]         counter_o,
  output logic [NUM_SRC-1:0]           overflow
);

  localparam int SW = $clog2(NUM_SRC);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            state_q, state_d;
  logic [NUM_SRC-1:0]                full_q;
  logic [NUM_SRC-1:0][REC_WIDTH-1:0] slot_q;
  logic [NUM_SRC-1:0]                overflow_q;
  logic [REC_WIDTH-1:0]              data_q, data_d;
  logic [SW-1:0]                     src_q, src_d;
  logic [SW-1:0]                     lastGrant_q, lastGrant_d;
  logic [CNT_WIDTH-1:0]              cnt_q;
  logic [NUM_SRC-1:0]                clearSlot;
  logic                              found;
  logic [SW-1:0]                     grantIdx;
  logic [SW-1:0]                     cand;

  // Round-robin search: first full slot starting just after the last grant.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SW'((int'(lastGrant_q) + k) % NUM_SRC);
      if (!found && full_q[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
  end

  // Next-state and output logic; a grant copies the slot out and frees it.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    src_d       = src_q;
    lastGrant_d = lastGrant_q;
    clearSlot   = '0;
    trace_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          data_d              = slot_q[grantIdx];
          src_d               = grantIdx;
          lastGrant_d         = grantIdx;
          clearSlot[grantIdx] = 1'b1;
          state_d             = SEND;
        end
      end
      SEND: begin
        trace_valid = 1'b1;
        if (trace_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter registers; last grant resets to the top index so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      src_q       <= '0;
      lastGrant_q <= SW'(NUM_SRC - 1);
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      src_q       <= src_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Holding slots: a slot being granted this cycle may be refilled at once;
  // a strobe into a slot that stays full is dropped and flagged stickily.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      slot_q     <= '0;
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i]) begin
          if (!full_q[i] || clearSlot[i]) begin
            slot_q[i] <= src_data[i*REC_WIDTH +: REC_WIDTH];
            full_q[i] <= 1'b1;
          end else begin
            overflow_q[i] <= 1'b1;
          end
        end else if (clearSlot[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Shared cycle counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (trace_en) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign trace_data = data_q;
  assign trace_src  = src_q;
  assign counter_o  = cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Self-checking bench for trace_arbiter, built with a 4-bit counter so the wrap
// can be reached in a handful of cycles. Expected records go into a queue when
// the sources are pulsed and are compared on each valid/ready handshake.
module tb_trace_arbiter;

  localparam int NS = 4;
  localparam int RW = 128;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              trace_en;
  logic [NS-1:0]     src_valid;
  logic [NS*RW-1:0]  src_data;
  logic              trace_ready;
  logic              trace_valid;
  logic [RW-1:0]     trace_data;
  logic [1:0]        trace_src;
  logic [CW-1:0]     counter_o;
  logic [NS-1:0]     overflow;

  typedef struct packed {
    logic [1:0]    src;
    logic [RW-1:0] data;
  } rec_t;

  rec_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  trace_arbiter #(.NUM_SRC(NS), .REC_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .trace_en    (trace_en),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trace_src   (trace_src),
    .counter_o   (counter_o),
    .overflow    (overflow)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Drives one source's record lane and queues the record it should produce.
  task applyStimulus(input int idx, input logic [RW-1:0] d, input logic expect_out);
    src_valid[idx]        = 1'b1;
    src_data[idx*RW +: RW] = d;
    if (expect_out) expQ.push_back({2'(idx), d});
  endtask

  task test_reset;
    rst = 1'b1; trace_en = 1'b0; src_valid = '0; src_data = '0; trace_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (trace_valid !== 1'b0 || trace_data !== '0 || trace_src !== 2'd0 ||
        counter_o !== '0 || overflow !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h src=%0d cnt=%0d ovf=%b, want all zero",
               trace_valid, trace_data, trace_src, counter_o, overflow);
    end
    rst = 1'b0;
  endtask

  task test_fairness;
    rec_t r;
    int   lastCyc;
    for (int burst = 0; burst < 2; burst++) begin
      trace_ready = 1'b1;
      for (int i = 0; i < NS; i++) applyStimulus(i, RW'(32'hF000 + 32'(burst*16 + i)), 1'b1);
      @(negedge clk);
      src_valid = '0;
      lastCyc = -1;
      for (int cyc = 0; cyc < 40 && expQ.size() > 0; cyc++) begin
        if (trace_valid && trace_ready) begin
          r = expQ.pop_front();
          checks++;
          if (trace_src !== r.src || trace_data !== r.data) begin
            errors++;
            $display("[TB] FAIL fairness_grant: got src=%0d data=%h, want src=%0d data=%h",
                     trace_src, trace_data, r.src, r.data);
          end
          if (lastCyc >= 0) begin
            checks++;
            if (cyc - lastCyc != 2) begin
              errors++;
              $display("[TB] FAIL fairness_spacing: got %0d cycles, want 2", cyc - lastCyc);
            end
          end
          lastCyc = cyc;
        end
        @(negedge clk);
      end
      if (expQ.size() > 0) begin
        errors++; checks++;
        $display("[TB] FAIL fairness_timeout: got %0d records missing, want 0", expQ.size());
        expQ.delete();
      end
    end
  endtask

  task test_single;
    rec_t r;
    int   hsCyc;
    hsCyc = -1;
    trace_ready = 1'b1;
    applyStimulus(2, RW'(8'hA5), 1'b1);
    @(negedge clk);
    src_valid = '0;
    for (int cyc = 0; cyc < 20 && expQ.size() > 0; cyc++) begin
      if (trace_valid && trace_ready) begin
        r = expQ.pop_front();
        hsCyc = cyc;
        checks++;
        if (trace_src !== r.src || trace_data !== r.data) begin
          errors++;
          $display("[TB] FAIL single_record: got src=%0d data=%h, want src=%0d data=%h",
                   trace_src, trace_data, r.src, r.data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (hsCyc != 1) begin
      errors++;
      $display("[TB] FAIL single_latency: got handshake at cycle %0d, want 1", hsCyc);
    end
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_one_cycle: got valid=%b after handshake, want 0", trace_valid);
    end
    expQ.delete();
  endtask

  task test_backpressure;
    rec_t r;
    trace_ready = 1'b0;
    applyStimulus(1, RW'(8'h11), 1'b1);
    @(negedge clk);
    applyStimulus(1, RW'(8'h22), 1'b1);
    @(negedge clk);
    applyStimulus(1, RW'(8'h33), 1'b0);
    @(negedge clk);
    src_valid = '0;
    checks++;
    if (overflow !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bp_overflow: got ovf=%b, want 0010", overflow);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== RW'(8'h11) || trace_src !== 2'd1) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid=%b src=%0d data=%h, want 1 1 11",
                 trace_valid, trace_src, trace_data);
      end
      @(negedge clk);
    end
    trace_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && expQ.size() > 0; cyc++) begin
      if (trace_valid && trace_ready) begin
        r = expQ.pop_front();
        checks++;
        if (trace_src !== r.src || trace_data !== r.data) begin
          errors++;
          $display("[TB] FAIL bp_drain: got src=%0d data=%h, want src=%0d data=%h",
                   trace_src, trace_data, r.src, r.data);
        end
      end
      @(negedge clk);
    end
    if (expQ.size() > 0) begin
      errors++; checks++;
      $display("[TB] FAIL bp_timeout: got %0d records missing, want 0", expQ.size());
      expQ.delete();
    end
    checks++;
    if (overflow !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bp_sticky: got ovf=%b, want 0010", overflow);
    end
  endtask

  task test_refill;
    rec_t r;
    trace_ready = 1'b1;
    applyStimulus(0, RW'(8'h44), 1'b1);
    @(negedge clk);
    applyStimulus(0, RW'(8'h55), 1'b1);
    @(negedge clk);
    src_valid = '0;
    for (int cyc = 0; cyc < 20 && expQ.size() > 0; cyc++) begin
      if (trace_valid && trace_ready) begin
        r = expQ.pop_front();
        checks++;
        if (trace_src !== r.src || trace_data !== r.data) begin
          errors++;
          $display("[TB] FAIL refill_record: got src=%0d data=%h, want src=%0d data=%h",
                   trace_src, trace_data, r.src, r.data);
        end
      end
      @(negedge clk);
    end
    if (expQ.size() > 0) begin
      errors++; checks++;
      $display("[TB] FAIL refill_timeout: got %0d records missing, want 0", expQ.size());
      expQ.delete();
    end
    checks++;
    if (overflow !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL refill_no_overflow: got ovf=%b, want 0010", overflow);
    end
  endtask

  task test_counter;
    logic [CW-1:0] expCnt;
    expCnt = '0;
    trace_en = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      expCnt = expCnt + 1'b1;
      checks++;
      if (counter_o !== expCnt) begin
        errors++;
        $display("[TB] FAIL counter_count: got %0d, want %0d", counter_o, expCnt);
      end
    end
    trace_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (counter_o !== expCnt) begin
        errors++;
        $display("[TB] FAIL counter_hold: got %0d, want %0d", counter_o, expCnt);
      end
    end
  endtask

  task test_async_reset;
    rec_t r;
    trace_en = 1'b1;
    trace_ready = 1'b0;
    applyStimulus(3, RW'(8'h77), 1'b0);
    @(negedge clk);
    applyStimulus(1, RW'(8'h66), 1'b0);
    @(negedge clk);
    src_valid = '0;
    checks++;
    if (trace_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_setup: got valid=%b, want 1", trace_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (trace_valid !== 1'b0 || counter_o !== '0 || overflow !== '0 ||
        trace_data !== '0 || trace_src !== 2'd0) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got valid=%b cnt=%0d ovf=%b data=%h src=%0d, want all zero",
               trace_valid, counter_o, overflow, trace_data, trace_src);
    end
    #1 rst = 1'b0;
    trace_en = 1'b0;
    @(negedge clk);
    trace_ready = 1'b1;
    for (int i = 0; i < NS; i++) applyStimulus(i, RW'(32'hB000 + 32'(i)), 1'b1);
    @(negedge clk);
    src_valid = '0;
    for (int cyc = 0; cyc < 40 && expQ.size() > 0; cyc++) begin
      if (trace_valid && trace_ready) begin
        r = expQ.pop_front();
        checks++;
        if (trace_src !== r.src || trace_data !== r.data) begin
          errors++;
          $display("[TB] FAIL areset_order: got src=%0d data=%h, want src=%0d data=%h",
                   trace_src, trace_data, r.src, r.data);
        end
      end
      @(negedge clk);
    end
    if (expQ.size() > 0) begin
      errors++; checks++;
      $display("[TB] FAIL areset_timeout: got %0d records missing, want 0", expQ.size());
      expQ.delete();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (trace_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL areset_no_ghost: got valid=%b src=%0d, want 0", trace_valid, trace_src);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_refill();
    test_counter();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
